// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// Request/response bundle for one port of the data-memory arbiter.
// The master modport is the side that issues requests.
interface ysyx_24100005_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rdata;
  logic              rsp_err;

  modport master (
    output req_valid, addr, wen, wdata, wmask, rsp_ready,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask, rsp_ready,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter sharing the npcmem port between IFU (m0) and LSU (m1).
// One outstanding transaction; request fields are latched on grant.
module ysyx_24100005_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic clk,
  input  logic rst,
  ysyx_24100005_mem_arbiter_if.slave  m0,
  ysyx_24100005_mem_arbiter_if.slave  m1,
  ysyx_24100005_mem_arbiter_if.master s,
  output logic busy,
  output logic grant_id
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              last_grant;
  logic              owner;
  logic              gnt;
  logic              acc0;
  logic              acc1;
  logic              own_rdy;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      m0.req_valid && m1.req_valid:  gnt = ~last_grant;
      m1.req_valid && !m0.req_valid: gnt = 1'b1;
      default:                       gnt = 1'b0;
    endcase
  end

  assign own_rdy = owner ? m1.rsp_ready : m0.rsp_ready;

  always_comb begin
    state_nx     = state;
    acc0         = 1'b0;
    acc1         = 1'b0;
    s.req_valid  = 1'b0;
    s.rsp_ready  = 1'b0;
    m0.rsp_valid = 1'b0;
    m1.rsp_valid = 1'b0;
    m0.rdata     = '0;
    m1.rdata     = '0;
    m0.rsp_err   = 1'b0;
    m1.rsp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        // rst gate keeps ready low while reset is held
        acc0 = rst && m0.req_valid && !gnt;
        acc1 = rst && m1.req_valid && gnt;
        if (acc0 || acc1) state_nx = ISSUE;
      end
      ISSUE: begin
        s.req_valid = 1'b1;
        if (s.req_ready) state_nx = WAIT_RSP;
      end
      WAIT_RSP: begin
        s.rsp_ready  = own_rdy;
        m0.rsp_valid = s.rsp_valid && !owner;
        m1.rsp_valid = s.rsp_valid && owner;
        m0.rdata     = s.rdata;
        m1.rdata     = s.rdata;
        m0.rsp_err   = s.rsp_err;
        m1.rsp_err   = s.rsp_err;
        if (s.rsp_valid && own_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign m0.req_ready = acc0;
  assign m1.req_ready = acc1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      owner      <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state <= state_nx;
      if (acc0 || acc1) begin
        owner      <= acc1;
        last_grant <= acc1;
        addr_q     <= acc1 ? m1.addr  : m0.addr;
        wen_q      <= acc1 ? m1.wen   : m0.wen;
        wdata_q    <= acc1 ? m1.wdata : m0.wdata;
        wmask_q    <= acc1 ? m1.wmask : m0.wmask;
      end
    end
  end

  assign s.addr   = addr_q;
  assign s.wen    = wen_q;
  assign s.wdata  = wdata_q;
  assign s.wmask  = wmask_q;
  assign busy     = (state != IDLE);
  assign grant_id = owner;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_ysyx_24100005_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic grant_id;

  always #5 clk = ~clk;

  ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0i ();
  ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1i ();
  ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) si ();

  ysyx_24100005_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0i),
    .m1       (m1i),
    .s        (si),
    .busy     (busy),
    .grant_id (grant_id)
  );

  typedef struct {
    bit          own;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  // model: queue holds the single outstanding transaction
  txn_t q[$];
  bit   issued;
  bit   last;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input bit m, input bit v, input logic [31:0] a,
                     input bit we, input logic [31:0] d,
                     input logic [3:0] mk);
    if (m) begin
      m1i.req_valid = v; m1i.addr = a; m1i.wen = we;
      m1i.wdata = d; m1i.wmask = mk;
    end else begin
      m0i.req_valid = v; m0i.addr = a; m0i.wen = we;
      m0i.wdata = d; m0i.wmask = mk;
    end
  endtask

  task automatic mem(input bit rq, input bit rv, input logic [31:0] rd,
                     input bit er);
    si.req_ready = rq;
    si.rsp_valid = rv;
    si.rdata     = rd;
    si.rsp_err   = er;
  endtask

  task automatic rr(input bit r0, input bit r1);
    m0i.rsp_ready = r0;
    m1i.rsp_ready = r1;
  endtask

  // called at negedge with inputs set; checks, then advances one cycle
  task automatic step();
    bit idle, w, own, e_r0, e_r1, e_sv, waiting, e_v0, e_v1, e_srr;
    txn_t t;
    #1;
    idle = (q.size() == 0);
    own  = idle ? 1'b0 : q[0].own;
    w    = (m0i.req_valid && m1i.req_valid) ? !last : m1i.req_valid;
    e_r0 = idle && m0i.req_valid && !w;
    e_r1 = idle && m1i.req_valid && w;
    chk("m0_req_ready", m0i.req_ready, e_r0);
    chk("m1_req_ready", m1i.req_ready, e_r1);
    e_sv = !idle && !issued;
    chk("s_req_valid", si.req_valid, e_sv);
    if (e_sv) begin
      chk("s_addr", si.addr, q[0].addr);
      chk("s_wen", si.wen, q[0].wen);
      chk("s_wdata", si.wdata, q[0].wdata);
      chk("s_wmask", si.wmask, q[0].wmask);
    end
    waiting = !idle && issued;
    e_v0  = waiting && !own && si.rsp_valid;
    e_v1  = waiting && own && si.rsp_valid;
    e_srr = waiting && (own ? m1i.rsp_ready : m0i.rsp_ready);
    chk("m0_rsp_valid", m0i.rsp_valid, e_v0);
    chk("m1_rsp_valid", m1i.rsp_valid, e_v1);
    chk("s_rsp_ready", si.rsp_ready, e_srr);
    if (e_v0) begin
      chk("m0_rdata", m0i.rdata, si.rdata);
      chk("m0_err", m0i.rsp_err, si.rsp_err);
    end
    if (e_v1) begin
      chk("m1_rdata", m1i.rdata, si.rdata);
      chk("m1_err", m1i.rsp_err, si.rsp_err);
    end
    chk("busy", busy, !idle);
    chk("grant_id", grant_id, last);
    @(posedge clk);
    if (e_r0 || e_r1) begin
      t.own   = w;
      t.addr  = w ? m1i.addr  : m0i.addr;
      t.wen   = w ? m1i.wen   : m0i.wen;
      t.wdata = w ? m1i.wdata : m0i.wdata;
      t.wmask = w ? m1i.wmask : m0i.wmask;
      q.push_back(t);
      last = w;
    end else if (e_sv && si.req_ready) begin
      issued = 1'b1;
    end else if (e_srr && si.rsp_valid) begin
      void'(q.pop_front());
      issued = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    mem(1, 1, 32'h0, 0);
    rr(1, 1);
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("drain", q.size(), 0);
  endtask

  initial begin
    bit exp_ord[4];
    int k;
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
    n_vec  = 0;
    n_err  = 0;
    issued = 0;
    last   = 0;
    rst    = 1'b0;
    drv(0, 1, 32'h8000_0000, 0, 32'h5, 4'hf);
    drv(1, 1, 32'h8000_0004, 1, 32'h6, 4'hf);
    mem(1, 1, 32'h1234_5678, 1);
    rr(1, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_m0_rdy", m0i.req_ready, 0);
    chk("rst_m1_rdy", m1i.req_ready, 0);
    chk("rst_sreq", si.req_valid, 0);
    chk("rst_srsp_rdy", si.rsp_ready, 0);
    chk("rst_m0_rv", m0i.rsp_valid, 0);
    chk("rst_m1_rv", m1i.rsp_valid, 0);
    chk("rst_addr", si.addr, 0);
    chk("rst_wdata", si.wdata, 0);
    chk("rst_wmask", si.wmask, 0);
    chk("rst_wen", si.wen, 0);
    chk("rst_rdata", m0i.rdata, 0);
    chk("rst_err", m0i.rsp_err, 0);
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    mem(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // m0 read, minimum latency
    drv(0, 1, 32'h8000_0000, 0, 0, 4'hf);
    mem(1, 0, 0, 0);
    #1 chk("lat_c0_ready", m0i.req_ready, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("lat_c1_sreq", si.req_valid, 1);
    step();
    mem(1, 1, 32'h0000_0013, 0);
    #1 chk("lat_c2_rv", m0i.rsp_valid, 1);
    chk("lat_c2_rdata", m0i.rdata, 32'h13);
    step();
    mem(0, 0, 0, 0);
    #1 chk("lat_c3_busy", busy, 0);
    step();

    // both masters requesting, instant memory
    drv(0, 1, 32'h8000_0200, 0, 0, 4'hf);
    drv(1, 1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'h1);
    mem(1, 1, 32'h0000_0077, 0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (m0i.req_ready || m1i.req_ready) begin
        if (k < 4) chk("tie_order", m1i.req_ready, exp_ord[k]);
        k++;
      end
      if (si.req_valid && si.wen) begin
        chk("m1_wr_addr", si.addr, 32'h8000_0100);
        chk("m1_wr_data", si.wdata, 32'hDEAD_BEEF);
        chk("m1_wr_mask", si.wmask, 4'h1);
      end
      step();
    end
    chk("tie_grants", k, 4);
    drain();

    // request and response backpressure
    mem(0, 0, 0, 0);
    drv(0, 1, 32'h8000_0010, 1, 32'h1111_1111, 4'h3);
    step();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, $urandom, 0, $urandom, 4'(i));
      #1 chk("bp_addr", si.addr, 32'h8000_0010);
      chk("bp_wdata", si.wdata, 32'h1111_1111);
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    mem(1, 0, 0, 0);
    step();
    rr(0, 1);
    mem(0, 1, 32'hABCD, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_srsp_rdy", si.rsp_ready, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    rr(1, 1);
    step();

    // spurious responses in IDLE and ISSUE, then error response to m1
    mem(0, 1, 32'h5555, 1);
    repeat (2) step();
    drv(1, 1, 32'h8000_0020, 0, 0, 4'hf);
    step();
    drv(1, 0, 0, 0, 0, 0);
    repeat (2) step();
    mem(1, 1, 32'h6666, 1);
    step();
    #1 chk("err_m1_rv", m1i.rsp_valid, 1);
    chk("err_flag", m1i.rsp_err, 1);
    chk("err_m0_rv", m0i.rsp_valid, 0);
    step();

    // asynchronous reset while waiting for a response
    mem(1, 0, 0, 0);
    drv(1, 1, 32'h8000_0300, 0, 0, 4'hf);
    step();
    drv(0, 1, 32'h8000_0400, 0, 0, 4'hf);
    step();
    mem(0, 0, 32'h9, 0);
    rr(0, 0);
    #2 rst = 1'b0;
    #1 chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_m0_rdy", m0i.req_ready, 0);
    chk("arst_m1_rdy", m1i.req_ready, 0);
    chk("arst_sreq", si.req_valid, 0);
    chk("arst_addr", si.addr, 0);
    q.delete();
    issued = 0;
    last   = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("arst_tie_m1", m1i.req_ready, 1);
    step();
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drv(0, $urandom_range(9, 0) < 6, $urandom, 1'($urandom),
          $urandom, 4'($urandom));
      drv(1, $urandom_range(9, 0) < 6, $urandom, 1'($urandom),
          $urandom, 4'($urandom));
      mem(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      rr($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
Name: ysyx_24100005_mem_arbiter

Overview:
- Shares the single data-memory port (the DPI-backed npcmem read/write path) between two requesters: instruction fetch (m0) and load/store unit (m1).
- Round-robin arbitration, one outstanding transaction, valid/ready handshakes on request and response channels.
- Request fields are registered on grant, so a master may change or drop its inputs after its request handshake.
- Sits between IFU/LSU and the memory-access block in the NPC top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MASK_W, DATA_W/8, write byte-mask width (one bit per byte).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mX_req_valid  in  1  master X (X=0,1) request valid.
- mX_req_ready  out  1  master X request accepted.
- mX_addr  in  ADDR_W  master X address.
- mX_wen  in  1  master X write (1) / read (0).
- mX_wdata  in  DATA_W  master X write data.
- mX_wmask  in  MASK_W  master X byte mask.
- mX_rsp_valid  out  1  response valid to master X.
- mX_rsp_ready  in  1  master X accepts response.
- m_rsp_rdata  out  DATA_W  read data, shared by both masters.
- m_rsp_err  out  1  error flag, shared by both masters.
- s_req_valid  out  1  request to memory.
- s_req_ready  in  1  memory accepts request.
- s_addr  out  ADDR_W  registered address.
- s_wen  out  1  registered write enable.
- s_wdata  out  DATA_W  registered write data.
- s_wmask  out  MASK_W  registered byte mask.
- s_rsp_valid  in  1  memory response valid.
- s_rsp_ready  out  1  arbiter accepts response.
- s_rdata  in  DATA_W  memory read data.
- s_rsp_err  in  1  memory error.
- busy  out  1  state != IDLE.
- grant_id  out  1  owner of current or last transaction.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RSP.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=0, owner=0.
  - s_addr/s_wdata/s_wmask/s_wen=0.
  - All *_valid, *_ready and busy outputs are 0; m_rsp_rdata=0, m_rsp_err=0.
  - Reset mid-transaction abandons it silently; no response is delivered.
- IDLE, combinational grant:
  - Only m0 valid -> grant m0. Only m1 valid -> grant m1.
  - Both valid -> grant the master that is not last_grant. Since last_grant resets to 0, m1 (LSU) wins the first tie.
  - mX_req_ready = (state==IDLE) && grant==X && mX_req_valid. At most one ready is asserted.
- IDLE, on handshake:
  - Register addr, wen, wdata and wmask into the s_* registers.
  - owner <= X, last_grant <= X, state -> ISSUE.
- IDLE, other rules:
  - A master deasserting valid before its ready has no effect.
  - mX_req_ready=0 in every state other than IDLE.
- ISSUE:
  - s_req_valid=1.
  - s_* fields are held stable until s_req_ready.
  - On s_req_ready, s_req_valid drops on the next cycle and state -> WAIT_RSP.
- WAIT_RSP:
  - s_rsp_ready = m<owner>_rsp_ready.
  - m<owner>_rsp_valid = s_rsp_valid; the non-owner rsp_valid=0.
  - m_rsp_rdata = s_rdata and m_rsp_err = s_rsp_err (combinational pass-through).
  - On s_rsp_valid && s_rsp_ready, state -> IDLE.
  - Writes also need a response; rdata is don't-care for writes.
- Outside WAIT_RSP: s_rsp_ready=0, and s_rsp_valid is ignored (no state change, nothing forwarded).
- Minimum latency:
  - Cycle 0: request accepted.
  - Cycle 1: s_req_valid high; a same-cycle s_req_ready completes the issue.
  - Cycle 2: earliest response (only if memory returns it combinationally).
  - Next grant is possible in the cycle after the response handshake, giving a throughput of one transaction per 3 cycles.
- Fairness: with both masters continuously requesting, grants strictly alternate m1, m0, m1, ...
- grant_id = owner (registered). busy = (state!=IDLE).

Test Plan:
- Reset release, then m0 read addr=0x8000_0000 with s_req_ready=1 and s_rdata=0x0000_0013 returned in cycle 2:
  - m0_req_ready in cycle 0, s_req_valid in cycle 1, m0_rsp_valid with rdata 0x13 in cycle 2.
  - busy falls in cycle 3.
- m0 and m1 both valid every cycle, with instant memory:
  - Grant order m1, m0, m1, m0, with grant_id following it.
  - m1 write addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=0x1 appears on s_* unchanged.
- Backpressure:
  - s_req_ready held 0 for 4 cycles: s_addr/s_wdata stay constant even though m0 changes its inputs after its handshake.
  - m0_rsp_ready held 0 for 3 cycles: s_rsp_ready stays 0 and state stays WAIT_RSP.
- Spurious s_rsp_valid=1 while in IDLE or ISSUE:
  - No mX_rsp_valid is produced and the state does not change.
- rst driven low during WAIT_RSP (asynchronous, mid-cycle):
  - All outputs go to 0 immediately.
  - After release, a pending m1 request is granted in the next cycle, as m1 wins the tie after reset.
- s_rsp_err=1 on m1 read: m1_rsp_valid=1 with m_rsp_err=1, and m0_rsp_valid stays 0.
